// File: rtl/ahb_manager_rr_arbiter_if.sv
// Requester/manager bundle for the round-robin AHB manager arbiter.
// slave is the arbiter's view; master is the environment driving it.
interface ahb_manager_rr_arbiter_if #(
    parameter int N   = 4,
    parameter int WDT = 32
);
    localparam int IW = (N > 1) ? $clog2(N) : 1;

    logic [N-1:0]     i_req;
    logic [N-1:0]     i_lock;
    logic [N*WDT-1:0] i_data;
    logic [N-1:0]     o_stall;
    logic             o_valid;
    logic [WDT-1:0]   o_data;
    logic [IW-1:0]    o_gnt_id;
    logic             i_stall;

    modport slave (
        input  i_req, i_lock, i_data, i_stall,
        output o_stall, o_valid, o_data, o_gnt_id
    );

    modport master (
        output i_req, i_lock, i_data, i_stall,
        input  o_stall, o_valid, o_data, o_gnt_id
    );
endinterface

// File: rtl/ahb_manager_rr_arbiter.sv
// Round-robin arbiter with capped locked bursts feeding one registered
// output word per beat toward the AHB manager, honouring its stall.
module ahb_manager_rr_arbiter #(
    parameter int N        = 4,
    parameter int WDT      = 32,
    parameter int MAX_HOLD = 16
) (
    input  logic                    i_clk,
    input  logic                    i_resetn,
    ahb_manager_rr_arbiter_if.slave bus
);
    localparam int IW = (N > 1) ? $clog2(N) : 1;
    localparam int CW = $clog2(MAX_HOLD + 1);

    typedef enum logic {ARB, OWN} state_t;

    state_t        state;
    logic [IW-1:0] last_id;
    logic [IW-1:0] owner;
    logic [IW-1:0] sel;
    logic [IW-1:0] cand;
    logic [CW-1:0] hold_cnt;
    logic          sel_valid;
    logic          can_load;
    logic          accept;

    assign can_load = !bus.o_valid || !bus.i_stall;
    assign accept   = can_load && sel_valid;

    // Descending scan so the nearest requester after last_id wins.
    always_comb begin
        sel       = owner;
        sel_valid = 1'b0;
        cand      = '0;
        if (state == OWN) begin
            sel_valid = bus.i_req[owner];
        end else begin
            for (int k = N; k >= 1; k--) begin
                cand = IW'((int'(last_id) + k) % N);
                if (bus.i_req[cand]) begin
                    sel       = cand;
                    sel_valid = 1'b1;
                end
            end
        end
    end

    always_comb begin
        bus.o_stall = '1;
        if (accept) bus.o_stall[sel] = 1'b0;
    end

    always_ff @(posedge i_clk or negedge i_resetn) begin
        if (!i_resetn) begin
            state        <= ARB;
            last_id      <= IW'(N - 1);
            owner        <= '0;
            hold_cnt     <= '0;
            bus.o_valid  <= 1'b0;
            bus.o_data   <= '0;
            bus.o_gnt_id <= '0;
        end else begin
            if (can_load) begin
                if (sel_valid) begin
                    bus.o_valid  <= 1'b1;
                    bus.o_data   <= bus.i_data[int'(sel)*WDT +: WDT];
                    bus.o_gnt_id <= sel;
                    last_id      <= sel;
                end else begin
                    bus.o_valid  <= 1'b0;
                end
            end
            // In OWN sel is the owner, so a cap release leaves last_id=owner.
            if (accept) begin
                if (state == ARB) begin
                    if (bus.i_lock[sel] && MAX_HOLD > 1) begin
                        state    <= OWN;
                        owner    <= sel;
                        hold_cnt <= CW'(1);
                    end
                end else if (bus.i_lock[owner]
                             && int'(hold_cnt) + 1 < MAX_HOLD) begin
                    hold_cnt <= hold_cnt + 1'b1;
                end else begin
                    state    <= ARB;
                    hold_cnt <= '0;
                end
            end else if (state == OWN && !bus.i_lock[owner]) begin
                state    <= ARB;
                hold_cnt <= '0;
            end
        end
    end
endmodule
